// File: rtl/pipe_exe.sv
// Execute stage: ID/EX pipeline register with stall/flush control, operand select and ALU.
// Presents the registered control bundle, store data and ALU result to the memory stage.
module pipe_exe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             stall,
  input  logic             flush,
  input  logic             IDwreg,
  input  logic             IDm2reg,
  input  logic             IDwmem,
  input  logic [3:0]       IDaluc,
  input  logic             IDshift,
  input  logic             IDaluimm,
  input  logic [4:0]       IDwn,
  input  logic [WIDTH-1:0] IDqa,
  input  logic [WIDTH-1:0] IDqb,
  input  logic [WIDTH-1:0] IDimmeOrSa,
  output logic             EXwreg,
  output logic             EXm2reg,
  output logic             EXwmem,
  output logic [4:0]       EXwn,
  output logic [WIDTH-1:0] EXalu,
  output logic [WIDTH-1:0] EXqb,
  output logic             EXzero,
  output logic             EXvalid
);

  logic             wreg_r;
  logic             m2reg_r;
  logic             wmem_r;
  logic [3:0]       aluc_r;
  logic             shift_r;
  logic             aluimm_r;
  logic [4:0]       wn_r;
  logic [WIDTH-1:0] qa_r;
  logic [WIDTH-1:0] qb_r;
  logic [WIDTH-1:0] imm_r;
  logic             valid_r;

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [4:0]       sa_s;
  logic [WIDTH-1:0] alu_s;

  // ID/EX register: flush loads an all-zero bubble and wins over stall
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wreg_r   <= 1'b0;
      m2reg_r  <= 1'b0;
      wmem_r   <= 1'b0;
      aluc_r   <= 4'd0;
      shift_r  <= 1'b0;
      aluimm_r <= 1'b0;
      wn_r     <= 5'd0;
      qa_r     <= {WIDTH{1'b0}};
      qb_r     <= {WIDTH{1'b0}};
      imm_r    <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
    end else if (flush) begin
      wreg_r   <= 1'b0;
      m2reg_r  <= 1'b0;
      wmem_r   <= 1'b0;
      aluc_r   <= 4'd0;
      shift_r  <= 1'b0;
      aluimm_r <= 1'b0;
      wn_r     <= 5'd0;
      qa_r     <= {WIDTH{1'b0}};
      qb_r     <= {WIDTH{1'b0}};
      imm_r    <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
    end else if (!stall) begin
      wreg_r   <= IDwreg;
      m2reg_r  <= IDm2reg;
      wmem_r   <= IDwmem;
      aluc_r   <= IDaluc;
      shift_r  <= IDshift;
      aluimm_r <= IDaluimm;
      wn_r     <= IDwn;
      qa_r     <= IDqa;
      qb_r     <= IDqb;
      imm_r    <= IDimmeOrSa;
      valid_r  <= 1'b1;
    end else begin
      valid_r  <= valid_r;
    end
  end

  // Operand select; shift amount comes from the immediate's low five bits
  always_comb begin
    a_s = qa_r;
    b_s = qb_r;
    if (shift_r) begin
      a_s = {{(WIDTH-5){1'b0}}, imm_r[4:0]};
    end else begin
      a_s = qa_r;
    end
    if (aluimm_r) begin
      b_s = imm_r;
    end else begin
      b_s = qb_r;
    end
    sa_s = a_s[4:0];
  end

  // ALU: aluc[3] only matters for the shift group (x011 / x111)
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (aluc_r[2:0])
      3'b000:  alu_s = a_s + b_s;
      3'b100:  alu_s = a_s - b_s;
      3'b001:  alu_s = a_s & b_s;
      3'b101:  alu_s = a_s | b_s;
      3'b010:  alu_s = a_s ^ b_s;
      3'b110:  alu_s = b_s << 16;
      3'b011: begin
        if (aluc_r[3]) begin
          alu_s = {WIDTH{1'b0}};
        end else begin
          alu_s = b_s << sa_s;
        end
      end
      3'b111: begin
        if (aluc_r[3]) begin
          alu_s = $signed(b_s) >>> sa_s;
        end else begin
          alu_s = b_s >> sa_s;
        end
      end
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  assign EXwreg  = wreg_r;
  assign EXm2reg = m2reg_r;
  assign EXwmem  = wmem_r;
  assign EXwn    = wn_r;
  assign EXqb    = qb_r;
  assign EXvalid = valid_r;
  assign EXalu   = alu_s;
  assign EXzero  = (alu_s == {WIDTH{1'b0}});

endmodule

// File: tb/tb_pipe_exe.sv
// Scoreboard bench for pipe_exe: a bundle-level model predicts the EX outputs after every
// edge; a negedge monitor pops and compares, plus directed constant checks from the test plan.
module tb_pipe_exe;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        IDwreg = 1'b0, IDm2reg = 1'b0, IDwmem = 1'b0, IDshift = 1'b0, IDaluimm = 1'b0;
  logic [3:0]  IDaluc = 4'd0;
  logic [4:0]  IDwn = 5'd0;
  logic [31:0] IDqa = 32'd0, IDqb = 32'd0, IDimmeOrSa = 32'd0;
  logic        EXwreg, EXm2reg, EXwmem, EXzero, EXvalid;
  logic [4:0]  EXwn;
  logic [31:0] EXalu, EXqb;

  always #5 clk = ~clk;

  pipe_exe #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .flush(flush),
    .IDwreg(IDwreg), .IDm2reg(IDm2reg), .IDwmem(IDwmem), .IDaluc(IDaluc),
    .IDshift(IDshift), .IDaluimm(IDaluimm), .IDwn(IDwn), .IDqa(IDqa), .IDqb(IDqb),
    .IDimmeOrSa(IDimmeOrSa),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem), .EXwn(EXwn), .EXalu(EXalu),
    .EXqb(EXqb), .EXzero(EXzero), .EXvalid(EXvalid)
  );

  typedef struct packed {
    logic        wreg, m2reg, wmem;
    logic [3:0]  aluc;
    logic        shift, aluimm;
    logic [4:0]  wn;
    logic [31:0] qa, qb, imm;
    logic        valid;
  } idb_t;

  typedef struct packed {
    logic        wreg, m2reg, wmem;
    logic [4:0]  wn;
    logic [31:0] alu, qb;
    logic        zero, valid;
  } exp_t;

  exp_t q[$];
  idb_t ex_m = '0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cmp = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_alu(input idb_t b);
    logic [31:0] a, bb;
    longint unsigned ua, ub, p, r;
    longint sx, sr;
    int sa;
    a  = b.shift ? (b.imm % 32) : b.qa;
    bb = b.aluimm ? b.imm : b.qb;
    sa = int'(a % 32);
    ua = a;
    ub = bb;
    p  = longint'(1) << sa;
    r  = 0;
    case (b.aluc)
      4'b0000, 4'b1000: r = ua + ub;
      4'b0100, 4'b1100: r = ua + 64'h1_0000_0000 - ub;
      4'b0001, 4'b1001: r = ua & ub;
      4'b0101, 4'b1101: r = ua | ub;
      4'b0010, 4'b1010: r = ua ^ ub;
      4'b0110, 4'b1110: r = (ub % 65536) * 65536;
      4'b0011:          r = ub * p;
      4'b0111:          r = ub / p;
      4'b1111: begin
        sx = longint'($signed(bb));
        if (sx >= 0) sr = sx / longint'(p);
        else         sr = (sx - longint'(p) + 1) / longint'(p);
        r = longint'(sr);
      end
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic exp_t mk_exp(input idb_t b);
    exp_t e;
    e.wreg  = b.wreg;
    e.m2reg = b.m2reg;
    e.wmem  = b.wmem;
    e.wn    = b.wn;
    e.qb    = b.qb;
    e.alu   = ref_alu(b);
    e.zero  = (e.alu == 32'd0);
    e.valid = b.valid;
    return e;
  endfunction

  // One clock edge: update the model exactly as the stage should, queue the prediction
  task automatic cyc();
    idb_t nb;
    @(posedge clk);
    nb = '{IDwreg, IDm2reg, IDwmem, IDaluc, IDshift, IDaluimm, IDwn, IDqa, IDqb, IDimmeOrSa, 1'b1};
    if (flush)       ex_m = '0;
    else if (!stall) ex_m = nb;
    q.push_back(mk_exp(ex_m));
    n_vec++;
    #1;
  endtask

  task automatic set_id(input logic wr, m2, wm, input logic [3:0] op, input logic sh, ai,
                        input logic [4:0] wn, input logic [31:0] qa, qb, imm);
    IDwreg = wr; IDm2reg = m2; IDwmem = wm; IDaluc = op; IDshift = sh; IDaluimm = ai;
    IDwn = wn; IDqa = qa; IDqb = qb; IDimmeOrSa = imm;
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  task automatic check_cleared(input string tag);
    cmp({tag, "_wreg"},  {31'd0, EXwreg},  32'd0);
    cmp({tag, "_m2reg"}, {31'd0, EXm2reg}, 32'd0);
    cmp({tag, "_wmem"},  {31'd0, EXwmem},  32'd0);
    cmp({tag, "_wn"},    {27'd0, EXwn},    32'd0);
    cmp({tag, "_alu"},   EXalu,            32'd0);
    cmp({tag, "_qb"},    EXqb,             32'd0);
    cmp({tag, "_zero"},  {31'd0, EXzero},  32'd1);
    cmp({tag, "_valid"}, {31'd0, EXvalid}, 32'd0);
  endtask

  // Monitor: every negedge with reset released, pop one prediction and compare all outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clrn && q.size() > 0) begin
        e = q.pop_front();
        cmp("sb_wreg",  {31'd0, EXwreg},  {31'd0, e.wreg});
        cmp("sb_m2reg", {31'd0, EXm2reg}, {31'd0, e.m2reg});
        cmp("sb_wmem",  {31'd0, EXwmem},  {31'd0, e.wmem});
        cmp("sb_wn",    {27'd0, EXwn},    {27'd0, e.wn});
        cmp("sb_alu",   EXalu,            e.alu);
        cmp("sb_qb",    EXqb,             e.qb);
        cmp("sb_zero",  {31'd0, EXzero},  {31'd0, e.zero});
        cmp("sb_valid", {31'd0, EXvalid}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    // Reset with inputs toggling and the clock running
    #1 clrn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_id(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom), $urandom(), $urandom(), $urandom());
      @(posedge clk);
    end
    @(negedge clk);
    check_cleared("reset");
    clrn = 1'b1;
    set_id(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd1, 32'd0, 32'd0, 32'd0);
    cyc();
    cmp("rel_wreg",  {31'd0, EXwreg},  32'd1);
    cmp("rel_valid", {31'd0, EXvalid}, 32'd1);

    // addi and wrap to zero
    set_id(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd2, 32'h0000_000F, 32'd0, 32'h0000_0003);
    cyc();
    cmp("addi_alu",  EXalu, 32'h0000_0012);
    cmp("addi_wn",   {27'd0, EXwn}, 32'd2);
    cmp("addi_zero", {31'd0, EXzero}, 32'd0);
    IDqa = 32'hFFFF_FFFD;
    cyc();
    cmp("addi_wrap_alu",  EXalu, 32'd0);
    cmp("addi_wrap_zero", {31'd0, EXzero}, 32'd1);

    // Shifts
    set_id(1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 5'd3, 32'd0, 32'h8000_0010, 32'd4);
    cyc();
    cmp("sll4", EXalu, 32'h0000_0100);
    IDaluc = 4'b0111;
    cyc();
    cmp("srl4", EXalu, 32'h0800_0001);
    IDaluc = 4'b1111;
    cyc();
    cmp("sra4", EXalu, 32'hF800_0001);
    IDimmeOrSa = 32'd31; IDqb = 32'h8000_0000;
    cyc();
    cmp("sra31", EXalu, 32'hFFFF_FFFF);

    // Store: EXqb is raw qb even with aluimm
    set_id(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h8);
    cyc();
    cmp("st_alu",  EXalu, 32'h108);
    cmp("st_qb",   EXqb, 32'hDEAD_BEEF);
    cmp("st_wmem", {31'd0, EXwmem}, 32'd1);
    cmp("st_wreg", {31'd0, EXwreg}, 32'd0);

    // Stall holds the sub result
    set_id(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 5'd4, 32'd9, 32'd4, 32'd0);
    cyc();
    cmp("sub_alu", EXalu, 32'd5);
    stall = 1'b1;
    set_id(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 5'd6, 32'd1, 32'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmp("stall_alu", EXalu, 32'd5);
    end
    stall = 1'b0;
    cyc();
    cmp("unstall_alu", EXalu, 32'd3);

    // Flush wins over stall
    set_id(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'd7, 32'd1, 32'd1, 32'd0);
    cyc();
    stall = 1'b1; flush = 1'b1;
    cyc();
    cmp("flush_valid", {31'd0, EXvalid}, 32'd0);
    cmp("flush_wreg",  {31'd0, EXwreg},  32'd0);
    cmp("flush_wmem",  {31'd0, EXwmem},  32'd0);
    cmp("flush_wn",    {27'd0, EXwn},    32'd0);
    cmp("flush_alu",   EXalu,            32'd0);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset between edges
    set_id(1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0, 5'd9, 32'h55, 32'hAA, 32'd0);
    cyc();
    @(negedge clk);
    #1 clrn = 1'b0;
    #1 check_cleared("async");
    ex_m = '0;
    #1 clrn = 1'b1;

    // Randomized traffic with stalls and flushes
    for (int i = 0; i < 1500; i++) begin
      set_id(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom), rnd_data(), rnd_data(), rnd_data());
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cyc();
    end
    stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
